// File: rtl/axis_stream_fifo.sv
// AXI-Stream synchronous FIFO with first-word fall-through output and an
// optional store-and-forward mode that holds output until a packet is complete.
module axis_stream_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [$clog2(DEPTH):0]      pkt_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + KW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Handshake: a word moves only on a rising edge where valid && ready are
  // both high on that side; valid never depends on ready, and the master
  // side holds its word stable until it is taken.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;
  logic          not_empty;
  logic          full;

  assign not_empty = (occupancy != '0);
  assign full      = (occupancy == FULL_COUNT);

  // Ready is gated by reset directly so it is low while reset is held and
  // high the moment reset releases on an empty FIFO.
  assign s_axis_tready = ARESETN && !full;

  always_comb begin
    m_axis_tvalid = not_empty;
    if (PACKET_MODE != 0) begin
      // A full FIFO releases a partial packet so oversize packets cannot deadlock.
      m_axis_tvalid = not_empty && ((pkt_count != '0) || full);
    end
  end

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

  assign wr_en   = s_axis_tvalid && s_axis_tready;
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr_en && s_axis_tlast;
  assign rd_last = rd_en && m_axis_tlast;

  // Storage is not reset; the pointers and counts define what is valid.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      case ({wr_last, rd_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: a cut-through instance (dut0) and a
// store-and-forward instance (dut1) share clock and reset.
module tb_axis_stream_fifo;

  logic        aclk;
  logic        aresetn;

  logic        s0_valid, s0_ready, s0_last, m0_valid, m0_ready, m0_last;
  logic [31:0] s0_data, m0_data;
  logic [3:0]  s0_keep, m0_keep;
  logic [4:0]  occ0, pkt0;

  logic        s1_valid, s1_ready, s1_last, m1_valid, m1_ready, m1_last;
  logic [31:0] s1_data, m1_data;
  logic [3:0]  s1_keep, m1_keep;
  logic [4:0]  occ1, pkt1;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  axis_stream_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut0 (
    .ACLK(aclk), .ARESETN(aresetn),
    .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready), .s_axis_tdata(s0_data),
    .s_axis_tkeep(s0_keep), .s_axis_tlast(s0_last),
    .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready), .m_axis_tdata(m0_data),
    .m_axis_tkeep(m0_keep), .m_axis_tlast(m0_last),
    .occupancy(occ0), .pkt_count(pkt0)
  );

  axis_stream_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1)) dut1 (
    .ACLK(aclk), .ARESETN(aresetn),
    .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready), .s_axis_tdata(s1_data),
    .s_axis_tkeep(s1_keep), .s_axis_tlast(s1_last),
    .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tdata(m1_data),
    .m_axis_tkeep(m1_keep), .m_axis_tlast(m1_last),
    .occupancy(occ1), .pkt_count(pkt1)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        wv;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        rr;
    logic        e_sr;
    logic        e_mv;
    logic        chk_d;
    logic [31:0] e_d;
    logic [3:0]  e_k;
    logic        e_l;
    logic [4:0]  e_occ;
    logic [4:0]  e_pkt;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic wv, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic rr, input logic e_sr,
                              input logic e_mv, input logic chk_d, input logic [31:0] e_d,
                              input logic [3:0] e_k, input logic e_l,
                              input logic [4:0] e_occ, input logic [4:0] e_pkt);
    vec_t v;
    v.wv = wv; v.d = d; v.k = k; v.l = l; v.rr = rr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.chk_d = chk_d; v.e_d = e_d;
    v.e_k = e_k; v.e_l = e_l; v.e_occ = e_occ; v.e_pkt = e_pkt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    int          wr_idx;
    int          rcvd;
    bit          seen;
    bit          wr_go;

    n_checks = 0;
    n_fail   = 0;
    aresetn  = 1'b0;
    s0_valid = 1'b0; s0_data = '0; s0_keep = '0; s0_last = 1'b0; m0_ready = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_keep = '0; s1_last = 1'b0; m1_ready = 1'b0;

    // Cycle-by-cycle vectors; expectations are the state before each edge.
    tbl[0] = mk(1, 32'h11, 4'h1, 0, 1,  1, 0, 0, 32'h0,  4'h0, 0, 5'd0, 5'd0);
    tbl[1] = mk(1, 32'h22, 4'h3, 0, 1,  1, 1, 1, 32'h11, 4'h1, 0, 5'd1, 5'd0);
    tbl[2] = mk(1, 32'h33, 4'hF, 1, 1,  1, 1, 1, 32'h22, 4'h3, 0, 5'd1, 5'd0);
    tbl[3] = mk(0, 32'h0,  4'h0, 0, 0,  1, 1, 1, 32'h33, 4'hF, 1, 5'd1, 5'd1);
    tbl[4] = mk(0, 32'h0,  4'h0, 0, 0,  1, 1, 1, 32'h33, 4'hF, 1, 5'd1, 5'd1);
    tbl[5] = mk(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'h33, 4'hF, 1, 5'd1, 5'd1);
    tbl[6] = mk(1, 32'h44, 4'hF, 1, 0,  1, 0, 0, 32'h0,  4'h0, 0, 5'd0, 5'd0);
    tbl[7] = mk(1, 32'h55, 4'h7, 1, 1,  1, 1, 1, 32'h44, 4'hF, 1, 5'd1, 5'd1);
    tbl[8] = mk(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'h55, 4'h7, 1, 5'd1, 5'd1);
    tbl[9] = mk(0, 32'h0,  4'h0, 0, 0,  1, 0, 0, 32'h0,  4'h0, 0, 5'd0, 5'd0);

    // Reset state while held, then ready right after release.
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_ready", s0_ready, 0);
    chk("rst_m_valid", m0_valid, 0);
    chk("rst_occ", occ0, 0);
    chk("rst_pkt", pkt0, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("post_rst_s_ready", s0_ready, 1);
    chk("post_rst_s_ready_pm1", s1_ready, 1);

    // Cut-through vectors
    for (int i = 0; i < 10; i++) begin
      s0_valid = tbl[i].wv; s0_data = tbl[i].d; s0_keep = tbl[i].k;
      s0_last = tbl[i].l; m0_ready = tbl[i].rr;
      chk($sformatf("vec%0d_s_ready", i), s0_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_m_valid", i), m0_valid, tbl[i].e_mv);
      chk($sformatf("vec%0d_occ", i), occ0, tbl[i].e_occ);
      chk($sformatf("vec%0d_pkt", i), pkt0, tbl[i].e_pkt);
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d_data", i), m0_data, tbl[i].e_d);
        chk($sformatf("vec%0d_keep", i), m0_keep, tbl[i].e_k);
        chk($sformatf("vec%0d_last", i), m0_last, tbl[i].e_l);
      end
      tick();
    end
    s0_valid = 1'b0; m0_ready = 1'b0;

    // Fill to full with downstream stalled
    for (int i = 0; i < 16; i++) begin
      s0_valid = 1'b1; s0_data = 32'h100 + i; s0_keep = 4'(i);
      s0_last = (i % 4 == 3);
      chk("fill_s_ready", s0_ready, 1);
      exp_q.push_back(32'h100 + i);
      tick();
    end
    chk("full_occ", occ0, 16);
    chk("full_s_ready", s0_ready, 0);
    chk("full_pkt", pkt0, 4);
    chk("full_head", m0_data, 32'h100);

    // 17th word offered while full is refused
    s0_data = 32'h1FF; s0_last = 1'b0;
    tick();
    chk("overflow_occ", occ0, 16);
    chk("overflow_head", m0_data, 32'h100);

    // Read while full: ready stays low this cycle, returns next cycle
    s0_data = 32'h200; s0_keep = 4'hF; s0_last = 1'b1; m0_ready = 1'b1;
    chk("full_read_s_ready", s0_ready, 0);
    chk("full_read_occ", occ0, 16);
    e = exp_q.pop_front();
    chk("full_read_data", m0_data, e);
    tick();
    m0_ready = 1'b0;
    chk("after_read_occ", occ0, 15);
    chk("after_read_s_ready", s0_ready, 1);
    exp_q.push_back(32'h200);
    tick();
    s0_valid = 1'b0;
    chk("refill_occ", occ0, 16);
    chk("refill_s_ready", s0_ready, 0);

    // Drain across the pointer wrap
    m0_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("drain_valid", m0_valid, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
      chk($sformatf("drain_data%0d", j), m0_data, e);
      tick();
    end
    m0_ready = 1'b0;
    chk("drain_occ", occ0, 0);
    chk("drain_pkt", pkt0, 0);
    chk("drain_valid_end", m0_valid, 0);

    // Store-and-forward: 4-word packet held until tlast is stored
    for (int i = 0; i < 4; i++) begin
      s1_valid = 1'b1; s1_data = 32'hA0 + i; s1_keep = 4'hF; s1_last = (i == 3);
      chk($sformatf("pm1_hold%0d", i), m1_valid, 0);
      tick();
    end
    s1_valid = 1'b0;
    chk("pm1_release_valid", m1_valid, 1);
    chk("pm1_pkt", pkt1, 1);
    chk("pm1_occ", occ1, 4);
    m1_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("pm1_data%0d", j), m1_data, 32'hA0 + j);
      chk($sformatf("pm1_last%0d", j), m1_last, (j == 3) ? 1 : 0);
      tick();
    end
    chk("pm1_pkt_end", pkt1, 0);
    chk("pm1_occ_end", occ1, 0);
    chk("pm1_valid_end", m1_valid, 0);

    // Store-and-forward: 20-word packet longer than the FIFO
    exp_q.delete();
    wr_idx = 0; rcvd = 0; seen = 0;
    for (int cyc = 0; cyc < 200 && rcvd < 20; cyc++) begin
      s1_valid = (wr_idx < 20); s1_data = 32'hB00 + wr_idx; s1_keep = 4'hF;
      s1_last = (wr_idx == 19);
      wr_go = s1_valid && s1_ready;
      if (m1_valid) begin
        if (!seen) begin
          seen = 1;
          chk("pm1_long_release_occ", occ1, 16);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
        chk($sformatf("pm1_long_data%0d", rcvd), m1_data, e);
        rcvd++;
      end
      if (wr_go) begin
        exp_q.push_back(32'hB00 + wr_idx);
        wr_idx++;
      end
      tick();
    end
    s1_valid = 1'b0; m1_ready = 1'b0;
    chk("pm1_long_count", rcvd, 20);
    chk("pm1_long_occ_end", occ1, 0);
    chk("pm1_long_pkt_end", pkt1, 0);

    // Asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) begin
      s0_valid = 1'b1; s0_data = 32'h300 + i; s0_keep = 4'hF; s0_last = (i == 2);
      tick();
    end
    s0_valid = 1'b0;
    chk("pre_rst_occ", occ0, 5);
    chk("pre_rst_pkt", pkt0, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_valid", m0_valid, 0);
    chk("async_rst_occ", occ0, 0);
    chk("async_rst_pkt", pkt0, 0);
    chk("async_rst_s_ready", s0_ready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("rerst_s_ready", s0_ready, 1);
    chk("rerst_valid", m0_valid, 0);
    chk("rerst_occ", occ0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
